// File: rtl/fcp_pkg.sv
// Shared FCP receiver definitions: timing defaults, RX state encoding and parity helper.
package fcp_pkg;

    localparam int UI_CYCLE_DEF  = 20;
    localparam int SYNC_MAX_DEF  = 7;
    localparam int PING_MIN_DEF  = 280;
    localparam int PING_MAX_DEF  = 360;
    localparam int RESET_MIN_DEF = 1000;
    localparam int RUN_W         = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_END,
        RX_PING,
        RX_RST
    } rx_state_e;

    // Odd parity over byte+parity bit: an even count of ones is an error.
    function automatic logic odd_par_err(input logic [8:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/fcp_rx_edge.sv
// FCP line front end: 2-FF synchroniser, edge detector and saturating run-length counter.
module fcp_rx_edge
    import fcp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             data,
    output logic             data_s,
    output logic             edge_det,
    output logic [RUN_W-1:0] run_cnt
);

    logic sync1;
    logic data_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1   <= 1'b0;
            data_s  <= 1'b0;
            data_d  <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync1  <= data;
            data_s <= sync1;
            data_d <= data_s;
            // run_cnt equals the length of the run just ended when edge_det is high
            if (edge_det)
                run_cnt <= RUN_W'(1);
            else if (run_cnt != '1)
                run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    assign edge_det = data_s ^ data_d;

endmodule

// File: rtl/slv_rx_ctrl.sv
// Slave-side FCP line receiver: recovers frame bytes, pings and line-reset pulses from the data wire.
module slv_rx_ctrl
    import fcp_pkg::*;
#(
    parameter int UI_CYCLE  = UI_CYCLE_DEF,
    parameter int SYNC_MAX  = SYNC_MAX_DEF,
    parameter int PING_MIN  = PING_MIN_DEF,
    parameter int PING_MAX  = PING_MAX_DEF,
    parameter int RESET_MIN = RESET_MIN_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       data,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_par_err,
    output logic       rx_ping,
    output logic       rx_frame_done,
    output logic [2:0] rx_byte_num,
    output logic       rx_err,
    output logic       rx_reset_det,
    output logic       rx_busy
);

    localparam int HALF_UI = UI_CYCLE / 2;
    localparam int END_CNT = 10 * UI_CYCLE;

    logic             data_s;
    logic             edge_det;
    logic [RUN_W-1:0] run_cnt;

    rx_state_e        state, state_nx;
    logic [2:0]       sync_num, sync_num_nx;
    logic [RUN_W-1:0] data_cnt, data_cnt_nx;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic [8:0]       shreg, shreg_nx;
    logic [2:0]       byte_cnt, byte_cnt_nx;
    logic [7:0]       rx_data_nx;
    logic             rx_par_err_nx, rx_vld_nx, rx_ping_nx, rx_frame_done_nx;
    logic             rx_err_nx, rx_reset_det_nx;
    logic [2:0]       rx_byte_num_nx;
    logic [RUN_W-1:0] sample_at;

    fcp_rx_edge u_edge (
        .clk      (clk),
        .rstn     (rstn),
        .data     (data),
        .data_s   (data_s),
        .edge_det (edge_det),
        .run_cnt  (run_cnt)
    );

    // data_cnt holds cycles since data start; bit n is sampled mid-UI
    assign sample_at = RUN_W'(HALF_UI) + RUN_W'(bit_cnt) * RUN_W'(UI_CYCLE);
    assign rx_busy   = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= RX_IDLE;
            sync_num      <= '0;
            data_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            byte_cnt      <= '0;
            rx_data       <= '0;
            rx_par_err    <= 1'b0;
            rx_vld        <= 1'b0;
            rx_ping       <= 1'b0;
            rx_frame_done <= 1'b0;
            rx_byte_num   <= '0;
            rx_err        <= 1'b0;
            rx_reset_det  <= 1'b0;
        end else begin
            state         <= state_nx;
            sync_num      <= sync_num_nx;
            data_cnt      <= data_cnt_nx;
            bit_cnt       <= bit_cnt_nx;
            shreg         <= shreg_nx;
            byte_cnt      <= byte_cnt_nx;
            rx_data       <= rx_data_nx;
            rx_par_err    <= rx_par_err_nx;
            rx_vld        <= rx_vld_nx;
            rx_ping       <= rx_ping_nx;
            rx_frame_done <= rx_frame_done_nx;
            rx_byte_num   <= rx_byte_num_nx;
            rx_err        <= rx_err_nx;
            rx_reset_det  <= rx_reset_det_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        sync_num_nx      = sync_num;
        data_cnt_nx      = data_cnt;
        bit_cnt_nx       = bit_cnt;
        shreg_nx         = shreg;
        byte_cnt_nx      = byte_cnt;
        rx_data_nx       = rx_data;
        rx_par_err_nx    = rx_par_err;
        rx_byte_num_nx   = rx_byte_num;
        rx_vld_nx        = 1'b0;
        rx_ping_nx       = 1'b0;
        rx_frame_done_nx = 1'b0;
        rx_err_nx        = 1'b0;
        rx_reset_det_nx  = 1'b0;

        if (data_s && run_cnt == RUN_W'(RESET_MIN)) begin
            rx_reset_det_nx = 1'b1;
            byte_cnt_nx     = '0;
            state_nx        = RX_RST;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (edge_det) begin
                        sync_num_nx = '0;
                        state_nx    = RX_SYNC;
                    end
                end
                RX_SYNC: begin
                    if (edge_det) begin
                        if (run_cnt <= RUN_W'(SYNC_MAX) && sync_num < 3'd4) begin
                            sync_num_nx = sync_num + 3'd1;
                        end else begin
                            rx_err_nx   = 1'b1;
                            byte_cnt_nx = '0;
                            state_nx    = RX_IDLE;
                        end
                    end else if (run_cnt == RUN_W'(HALF_UI)) begin
                        shreg_nx    = {8'h00, data_s};
                        data_cnt_nx = RUN_W'(HALF_UI + 1);
                        bit_cnt_nx  = 4'd1;
                        state_nx    = RX_DATA;
                    end
                end
                RX_DATA: begin
                    data_cnt_nx = data_cnt + RUN_W'(1);
                    if (data_cnt == sample_at) begin
                        shreg_nx   = {shreg[7:0], data_s};
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd8)
                            state_nx = RX_END;
                    end
                end
                RX_END: begin
                    data_cnt_nx = data_cnt + RUN_W'(1);
                    if (edge_det && data_cnt < RUN_W'(END_CNT)) begin
                        rx_data_nx    = shreg[8:1];
                        rx_par_err_nx = odd_par_err(shreg);
                        rx_vld_nx     = 1'b1;
                        if (byte_cnt != 3'd7)
                            byte_cnt_nx = byte_cnt + 3'd1;
                        sync_num_nx = 3'd1;
                        state_nx    = RX_SYNC;
                    end else if (data_cnt >= RUN_W'(END_CNT)) begin
                        // A run ending exactly at the byte boundary is too short for a ping
                        if (edge_det) begin
                            rx_err_nx   = 1'b1;
                            byte_cnt_nx = '0;
                            state_nx    = RX_IDLE;
                        end else begin
                            state_nx = RX_PING;
                        end
                    end
                end
                RX_PING: begin
                    if (edge_det) begin
                        if (run_cnt >= RUN_W'(PING_MIN) && run_cnt <= RUN_W'(PING_MAX)) begin
                            rx_ping_nx = 1'b1;
                            if (byte_cnt != '0) begin
                                rx_frame_done_nx = 1'b1;
                                rx_byte_num_nx   = byte_cnt;
                            end
                        end else begin
                            rx_err_nx = 1'b1;
                        end
                        byte_cnt_nx = '0;
                        state_nx    = RX_IDLE;
                    end else if (run_cnt > RUN_W'(PING_MAX) && !data_s) begin
                        rx_err_nx   = 1'b1;
                        byte_cnt_nx = '0;
                        state_nx    = RX_IDLE;
                    end
                end
                RX_RST: begin
                    if (!data_s)
                        state_nx = RX_IDLE;
                end
                default: state_nx = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slv_rx_ctrl.sv
// Scoreboard bench for slv_rx_ctrl: directed line waveforms, expected events queued, monitor compares.
module tb_slv_rx_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       data = 1'b0;
    logic [7:0] rx_data;
    logic       rx_vld, rx_par_err, rx_ping, rx_frame_done;
    logic [2:0] rx_byte_num;
    logic       rx_err, rx_reset_det, rx_busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          rst_det_cyc = -1;
    logic        lvl = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] obs, exp_w;
    int          n_ev;

    slv_rx_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .data          (data),
        .rx_data       (rx_data),
        .rx_vld        (rx_vld),
        .rx_par_err    (rx_par_err),
        .rx_ping       (rx_ping),
        .rx_frame_done (rx_frame_done),
        .rx_byte_num   (rx_byte_num),
        .rx_err        (rx_err),
        .rx_reset_det  (rx_reset_det),
        .rx_busy       (rx_busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // event words: [15:13] kind, [12:5] byte, [4] parity error, [3] frame done, [2:0] byte count
    function automatic logic [15:0] mk_vld(input logic [7:0] b, input logic pe);
        return {3'd1, b, pe, 1'b0, 3'd0};
    endfunction
    function automatic logic [15:0] mk_ping(input logic fd, input logic [2:0] num);
        return {3'd2, 8'h00, 1'b0, fd, num};
    endfunction
    function automatic logic [15:0] mk_err();
        return {3'd3, 13'd0};
    endfunction
    function automatic logic [15:0] mk_rst();
        return {3'd4, 13'd0};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            n_ev = int'(rx_vld) + int'(rx_ping) + int'(rx_err) + int'(rx_reset_det);
            if (n_ev > 1) begin
                checks++;
                errors++;
                $display("FAIL multi_pulse got %0d pulses at cycle %0d want at most 1", n_ev, cyc);
            end
            if (rx_frame_done && !rx_ping) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone got rx_frame_done=1 rx_ping=0 at cycle %0d", cyc);
            end
            if (n_ev > 0) begin
                if (rx_vld)
                    obs = mk_vld(rx_data, rx_par_err);
                else if (rx_ping)
                    obs = mk_ping(rx_frame_done, rx_frame_done ? rx_byte_num : 3'd0);
                else if (rx_err)
                    obs = mk_err();
                else begin
                    obs = mk_rst();
                    rst_det_cyc = cyc;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got %h want none at cycle %0d", obs, cyc);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (obs !== exp_w) begin
                        errors++;
                        $display("FAIL event got %h want %h at cycle %0d", obs, exp_w, cyc);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        lvl  = ~lvl;
        data = lvl;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        int t;
        toggle();
        t = 1;
        while (t < 2 || lvl != b[7]) begin
            wait_cyc(5);
            toggle();
            t++;
        end
        wait_cyc(20);
        for (int i = 6; i >= 0; i--) begin
            lvl  = b[i];
            data = lvl;
            wait_cyc(20);
        end
        lvl  = (~^b) ^ flip;
        data = lvl;
        wait_cyc(20);
    endtask

    task automatic send_ping(input int hold);
        toggle();
        if (lvl == 1'b0) begin
            wait_cyc(5);
            toggle();
        end
        wait_cyc(hold);
        toggle();
        wait_cyc(20);
    endtask

    task automatic check_idle_outputs(input string name);
        logic [17:0] v;
        v = {rx_data, rx_vld, rx_par_err, rx_ping, rx_frame_done, rx_byte_num,
             rx_err, rx_reset_det, rx_busy};
        checks++;
        if (v !== 18'd0) begin
            errors++;
            $display("FAIL %s got %h want 0", name, v);
        end
    endtask

    initial begin
        rstn = 1'b0;
        data = 1'b0;
        lvl  = 1'b0;
        wait_cyc(3);
        #1 check_idle_outputs("reset_state");
        @(negedge clk);
        rstn = 1'b1;
        wait_cyc(30);

        // standalone ping
        exp_q.push_back(mk_ping(1'b0, 3'd0));
        send_ping(320);
        wait_cyc(20);

        // two-byte frame
        exp_q.push_back(mk_vld(8'hA5, 1'b0));
        exp_q.push_back(mk_vld(8'h3C, 1'b0));
        exp_q.push_back(mk_ping(1'b1, 3'd2));
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_ping(320);
        wait_cyc(20);

        // same frame, first parity bit flipped
        exp_q.push_back(mk_vld(8'hA5, 1'b1));
        exp_q.push_back(mk_vld(8'h3C, 1'b0));
        exp_q.push_back(mk_ping(1'b1, 3'd2));
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_ping(320);
        wait_cyc(20);

        // line reset mid-byte
        exp_q.push_back(mk_rst());
        rst_det_cyc = -1;
        toggle(); wait_cyc(5);
        toggle(); wait_cyc(5);
        toggle(); wait_cyc(20);
        lvl = 1'b0; data = lvl; wait_cyc(20);
        lvl = 1'b1; data = lvl; rise_cyc = cyc;
        wait_cyc(2000);
        lvl = 1'b0; data = lvl;
        wait_cyc(10);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset got %b want 0", rx_busy);
        end
        checks++;
        if (rst_det_cyc - rise_cyc < 1001 || rst_det_cyc - rise_cyc > 1005) begin
            errors++;
            $display("FAIL reset_latency got %0d want 1001..1005", rst_det_cyc - rise_cyc);
        end
        wait_cyc(20);

        // sync pulse too long, then a valid ping
        exp_q.push_back(mk_err());
        exp_q.push_back(mk_ping(1'b0, 3'd0));
        toggle(); wait_cyc(8);
        toggle(); wait_cyc(30);
        send_ping(320);
        wait_cyc(20);

        // ping-like run of 200 after a byte, then a fresh frame counts from 1
        exp_q.push_back(mk_vld(8'h5A, 1'b0));
        exp_q.push_back(mk_err());
        exp_q.push_back(mk_vld(8'hC3, 1'b0));
        exp_q.push_back(mk_ping(1'b1, 3'd1));
        send_byte(8'h5A, 1'b0);
        send_ping(200);
        send_byte(8'hC3, 1'b0);
        send_ping(320);
        wait_cyc(20);

        // asynchronous reset mid-byte clears everything
        exp_q.push_back(mk_vld(8'h81, 1'b0));
        exp_q.push_back(mk_ping(1'b0, 3'd0));
        send_byte(8'h81, 1'b0);
        toggle();
        wait_cyc(15);
        rstn = 1'b0;
        #1 check_idle_outputs("async_reset");
        lvl  = 1'b0;
        data = lvl;
        wait_cyc(5);
        rstn = 1'b1;
        wait_cyc(20);
        send_ping(320);

        // drain with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d outstanding want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
